// File: rtl/control_link_arbiter.sv
// control_link_arbiter: round-robin arbiter that shares one link master
// between NREQ requesters. It holds at most one transaction at a time,
// watches it with a timeout, and resets the master after a timeout or link
// error before the next requester is granted.
module control_link_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 4095
) (
    input  logic                 byte_clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_write,
    input  logic [16*NREQ-1:0]   req_addr,
    input  logic [32*NREQ-1:0]   req_wdata,
    output logic [NREQ-1:0]      resp_done,
    output logic [NREQ-1:0]      resp_err,
    output logic [31:0]          resp_rdata,
    output logic [NREQ-1:0]      grant,
    output logic [15:0]          m_address,
    output logic [31:0]          m_dataOut,
    output logic                 m_requestIsWrite,
    output logic                 m_initiateRequest,
    output logic                 m_reset,
    input  logic                 m_busy,
    input  logic                 m_done,
    input  logic                 m_error,
    input  logic [31:0]          m_dataIn
);

    localparam int IW = $clog2(NREQ);
    // The counter is at least 12 bits wide, and wider when TIMEOUT needs it.
    localparam int TW = ($clog2(TIMEOUT + 1) > 12) ? $clog2(TIMEOUT + 1) : 12;
    // Abort on the cycle in which the counter would reach TIMEOUT, so the
    // error response appears TIMEOUT cycles after ISSUE is entered.
    localparam logic [TW-1:0] TLIMIT = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DONE, RELEASE, RECOVER} state_t;

    state_t          state_reg;
    logic [IW-1:0]   last_reg;
    logic [TW-1:0]   tcnt_reg;
    logic [1:0]      mrst_cnt_reg;
    logic            m_reset_reg;

    logic [15:0]     addr_arr  [NREQ];
    logic [31:0]     wdata_arr [NREQ];

    logic            win_found;
    logic [IW-1:0]   win_idx;
    logic [IW:0]     cand;
    logic            timeout_hit;
    logic            done_now;
    logic            abort_now;

    // Unpack the flat request buses into per-requester words.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = req_addr[16*gi +: 16];
            assign wdata_arr[gi] = req_wdata[32*gi +: 32];
        end
    endgenerate

    // Round-robin search starting one past the last granted index; walking
    // from the farthest candidate back lets the nearest one win.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = {1'b0, last_reg} + (IW+1)'(k);
            if (cand >= (IW+1)'(NREQ)) begin
                cand = cand - (IW+1)'(NREQ);
            end
            if (req_valid[cand[IW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IW-1:0];
            end
        end
    end

    // Completion and abort conditions; a link error beats m_done, and
    // m_done beats a timeout landing in the same cycle.
    always_comb begin
        timeout_hit = (tcnt_reg >= TLIMIT);
        done_now    = (state_reg == WAIT_DONE) && m_done;
        abort_now   = m_error || (timeout_hit && !done_now);
    end

    // The master is held in reset for as long as the block itself is.
    assign m_reset = m_reset_reg | reset;

    // Transaction FSM with registered grant, response and master outputs.
    always_ff @(posedge byte_clk) begin
        if (reset) begin
            state_reg         <= IDLE;
            grant             <= '0;
            resp_done         <= '0;
            resp_err          <= '0;
            resp_rdata        <= '0;
            m_address         <= '0;
            m_dataOut         <= '0;
            m_requestIsWrite  <= 1'b0;
            m_initiateRequest <= 1'b0;
            last_reg          <= IW'(NREQ - 1);
            tcnt_reg          <= '0;
            mrst_cnt_reg      <= '0;
            m_reset_reg       <= 1'b0;
        end else begin
            resp_done  <= '0;
            resp_err   <= '0;
            resp_rdata <= '0;
            case (state_reg)
                IDLE: begin
                    if (win_found && !m_error) begin
                        grant             <= NREQ'(1) << win_idx;
                        last_reg          <= win_idx;
                        m_address         <= addr_arr[win_idx];
                        m_dataOut         <= wdata_arr[win_idx];
                        m_requestIsWrite  <= req_write[win_idx];
                        m_initiateRequest <= 1'b1;
                        tcnt_reg          <= '0;
                        state_reg         <= ISSUE;
                    end
                end
                ISSUE, WAIT_DONE: begin
                    if (tcnt_reg != {TW{1'b1}}) begin
                        tcnt_reg <= tcnt_reg + 1'b1;
                    end
                    if (abort_now) begin
                        resp_done         <= grant;
                        resp_err          <= grant;
                        m_initiateRequest <= 1'b0;
                        m_reset_reg       <= 1'b1;
                        mrst_cnt_reg      <= 2'd2;
                        state_reg         <= RECOVER;
                    end else if (done_now) begin
                        resp_done         <= grant;
                        resp_rdata        <= m_requestIsWrite ? 32'h0 : m_dataIn;
                        m_initiateRequest <= 1'b0;
                        state_reg         <= RELEASE;
                    end else if ((state_reg == ISSUE) && m_busy) begin
                        state_reg <= WAIT_DONE;
                    end
                end
                RELEASE: begin
                    if (!m_done) begin
                        grant     <= '0;
                        state_reg <= IDLE;
                    end
                end
                RECOVER: begin
                    if (mrst_cnt_reg != 2'd0) begin
                        mrst_cnt_reg <= mrst_cnt_reg - 2'd1;
                        m_reset_reg  <= (mrst_cnt_reg == 2'd2);
                    end else if (!m_busy && !m_done) begin
                        grant     <= '0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_control_link_arbiter.sv
// Self-checking bench for control_link_arbiter: directed vector table,
// hand-written corner sequences and a randomized phase against a
// transaction-level round-robin model.
module tb_control_link_arbiter;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 20;

    logic                byte_clk = 1'b0;
    logic                reset;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_write;
    logic [16*NREQ-1:0]  req_addr;
    logic [32*NREQ-1:0]  req_wdata;
    logic [NREQ-1:0]     resp_done;
    logic [NREQ-1:0]     resp_err;
    logic [31:0]         resp_rdata;
    logic [NREQ-1:0]     grant;
    logic [15:0]         m_address;
    logic [31:0]         m_dataOut;
    logic                m_requestIsWrite;
    logic                m_initiateRequest;
    logic                m_reset;
    logic                m_busy;
    logic                m_done;
    logic                m_error;
    logic [31:0]         m_dataIn;

    logic [15:0] ra  [NREQ];
    logic [31:0] rwd [NREQ];
    logic        rw  [NREQ];

    int checks = 0;
    int errors = 0;
    int m_lat  = 2;
    int mcnt   = 0;

    typedef struct {
        logic [NREQ-1:0] valid;
        logic            write;
        logic [15:0]     addr;
        logic [31:0]     wdata;
        int              lat;
        logic [NREQ-1:0] exp_grant;
    } vec_t;

    vec_t vecs [8];

    control_link_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .byte_clk(byte_clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_done(resp_done), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .grant(grant),
        .m_address(m_address), .m_dataOut(m_dataOut),
        .m_requestIsWrite(m_requestIsWrite), .m_initiateRequest(m_initiateRequest),
        .m_reset(m_reset), .m_busy(m_busy), .m_done(m_done),
        .m_error(m_error), .m_dataIn(m_dataIn)
    );

    always #5 byte_clk = ~byte_clk;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_pack
            assign req_addr[16*gi +: 16]  = ra[gi];
            assign req_wdata[32*gi +: 32] = rwd[gi];
            assign req_write[gi]          = rw[gi];
        end
    endgenerate

    // Read data the master model returns for a given address.
    function automatic logic [31:0] rd_fn(input logic [15:0] a);
        if (a == 16'h1234) return 32'hDEADBEEF;
        return {~a, a};
    endfunction

    // Link master model: busy for m_lat cycles after initiate, then holds
    // done until initiate drops.
    always @(negedge byte_clk) begin
        if (reset === 1'b1 || m_reset === 1'b1) begin
            m_busy = 1'b0; m_done = 1'b0; mcnt = 0;
        end else if (m_initiateRequest !== 1'b1) begin
            m_busy = 1'b0; m_done = 1'b0; mcnt = 0;
        end else if (!m_done) begin
            if (mcnt >= m_lat) begin
                m_busy   = 1'b0;
                m_done   = 1'b1;
                m_dataIn = m_requestIsWrite ? 32'h0BAD0BAD : rd_fn(m_address);
            end else begin
                m_busy = 1'b1;
                mcnt++;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge byte_clk);
        #1;
        checks++;
        if ($countones(grant) > 1) begin
            errors++;
            $display("FAIL grant_onehot: got %b, want at most one bit", grant);
        end
    endtask

    task automatic wait_grant(input string name, input int limit);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < limit; c++) begin
            tick();
            if (grant != '0) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: no grant within %0d cycles", name, limit);
        end
    endtask

    // Returns the number of cycles until the resp_done pulse (limit+1 if none).
    task automatic wait_done(input string name, input int limit, output int n);
        bit ok;
        ok = 1'b0;
        n  = limit + 1;
        for (int c = 1; c <= limit; c++) begin
            tick();
            if (resp_done != '0) begin ok = 1'b1; n = c; break; end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: no resp_done within %0d cycles", name, limit);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_grant"},  grant, 0);
        chk({tag, "_done"},   resp_done, 0);
        chk({tag, "_err"},    resp_err, 0);
        chk({tag, "_rdata"},  resp_rdata, 0);
        chk({tag, "_maddr"},  m_address, 0);
        chk({tag, "_mdout"},  m_dataOut, 0);
        chk({tag, "_mwr"},    m_requestIsWrite, 0);
        chk({tag, "_minit"},  m_initiateRequest, 0);
        chk({tag, "_mreset"}, m_reset, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, idx, owner, rr_last, idle_run, exp_w;
        bit outstanding, saw;
        logic [NREQ-1:0] prev_grant, exp_g;
        logic [31:0] exp_rd;
        logic [15:0] exp_addr;

        vecs[0] = '{valid:4'b0001, write:1'b0, addr:16'h1234, wdata:32'h0,        lat:2, exp_grant:4'b0001};
        vecs[1] = '{valid:4'b0001, write:1'b1, addr:16'h0010, wdata:32'hCAFEF00D, lat:1, exp_grant:4'b0001};
        vecs[2] = '{valid:4'b0110, write:1'b0, addr:16'h0020, wdata:32'h0,        lat:3, exp_grant:4'b0010};
        vecs[3] = '{valid:4'b0110, write:1'b1, addr:16'h0030, wdata:32'h12345678, lat:2, exp_grant:4'b0100};
        vecs[4] = '{valid:4'b1001, write:1'b0, addr:16'h0040, wdata:32'h0,        lat:4, exp_grant:4'b1000};
        vecs[5] = '{valid:4'b1111, write:1'b0, addr:16'h0050, wdata:32'h0,        lat:1, exp_grant:4'b0001};
        vecs[6] = '{valid:4'b1010, write:1'b1, addr:16'h0060, wdata:32'hA5A5A5A5, lat:2, exp_grant:4'b0010};
        vecs[7] = '{valid:4'b0101, write:1'b0, addr:16'h0070, wdata:32'h0,        lat:3, exp_grant:4'b0100};

        reset = 1'b1; req_valid = '0; m_error = 1'b0;
        m_busy = 1'b0; m_done = 1'b0; m_dataIn = '0;
        for (int i = 0; i < NREQ; i++) begin ra[i] = '0; rwd[i] = '0; rw[i] = 1'b0; end

        // Reset state.
        repeat (3) tick();
        check_reset_outputs("reset");
        reset = 1'b0;
        tick();
        chk("reset_release_mreset", m_reset, 0);

        // Directed vector table.
        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < NREQ; i++) begin
                ra[i]  = vecs[v].addr + 16'(i);
                rwd[i] = vecs[v].wdata ^ 32'(i);
                rw[i]  = vecs[v].write;
            end
            m_lat = vecs[v].lat;
            req_valid = vecs[v].valid;
            wait_grant($sformatf("vec%0d_wait_grant", v), 20);
            chk($sformatf("vec%0d_grant", v), grant, vecs[v].exp_grant);
            idx = 0;
            for (int j = 0; j < NREQ; j++) if (vecs[v].exp_grant[j]) idx = j;
            chk($sformatf("vec%0d_maddr", v), m_address, vecs[v].addr + 16'(idx));
            chk($sformatf("vec%0d_mwrite", v), m_requestIsWrite, vecs[v].write);
            chk($sformatf("vec%0d_mdout", v), m_dataOut, vecs[v].wdata ^ 32'(idx));
            wait_done($sformatf("vec%0d_wait_done", v), 40, n);
            chk($sformatf("vec%0d_done", v), resp_done, vecs[v].exp_grant);
            chk($sformatf("vec%0d_err", v), resp_err, 0);
            chk($sformatf("vec%0d_rdata", v), resp_rdata,
                vecs[v].write ? 32'h0 : rd_fn(vecs[v].addr + 16'(idx)));
            req_valid = '0;
            tick();
            chk($sformatf("vec%0d_single_pulse", v), resp_done, 0);
        end

        // Timeout: master never finishes.
        ra[0] = 16'h0100; rw[0] = 1'b0; m_lat = 1000;
        req_valid = 4'b0001;
        wait_grant("to_wait_grant", 20);
        chk("to_grant", grant, 4'b0001);
        wait_done("to_wait_done", TIMEOUT + 5, n);
        chk("to_cycle", n, TIMEOUT);
        chk("to_done", resp_done, 4'b0001);
        chk("to_err", resp_err, 4'b0001);
        chk("to_rdata", resp_rdata, 0);
        chk("to_mreset1", m_reset, 1);
        req_valid = '0;
        tick();
        chk("to_mreset2", m_reset, 1);
        tick();
        chk("to_mreset_end", m_reset, 0);
        tick();
        chk("to_back_idle", grant, 0);

        // Done on the timeout cycle wins.
        ra[2] = 16'h0200; rw[2] = 1'b0; m_lat = TIMEOUT - 1;
        req_valid = 4'b0100;
        wait_grant("sim_wait_grant", 20);
        chk("sim_grant", grant, 4'b0100);
        saw = 1'b0;
        for (int c = 1; c <= TIMEOUT + 5; c++) begin
            tick();
            if (m_reset) saw = 1'b1;
            if (resp_done != '0) begin n = c; break; end
            n = c + 1;
        end
        chk("sim_cycle", n, TIMEOUT);
        chk("sim_done", resp_done, 4'b0100);
        chk("sim_err", resp_err, 0);
        chk("sim_rdata", resp_rdata, rd_fn(16'h0200));
        req_valid = '0;
        repeat (3) begin tick(); if (m_reset) saw = 1'b1; end
        chk("sim_no_mreset", saw, 0);

        // Link error during WAIT_DONE, then held error blocks new grants.
        ra[1] = 16'h0300; rw[1] = 1'b0; m_lat = 1000;
        req_valid = 4'b0010;
        wait_grant("lerr_wait_grant", 20);
        chk("lerr_grant", grant, 4'b0010);
        repeat (3) tick();
        m_error = 1'b1;
        tick();
        chk("lerr_done", resp_done, 4'b0010);
        chk("lerr_err", resp_err, 4'b0010);
        chk("lerr_rdata", resp_rdata, 0);
        chk("lerr_mreset", m_reset, 1);
        saw = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c >= 3 && grant != '0) saw = 1'b1;
        end
        chk("lerr_no_grant", saw, 0);
        m_lat = 2;
        m_error = 1'b0;
        wait_grant("lerr_regrant_wait", 20);
        chk("lerr_regrant", grant, 4'b0010);
        wait_done("lerr_re_wait_done", 40, n);
        chk("lerr_re_done", resp_done, 4'b0010);
        chk("lerr_re_err", resp_err, 0);
        chk("lerr_re_rdata", resp_rdata, rd_fn(16'h0300));
        req_valid = '0;
        tick();

        // Reset during WAIT_DONE abandons the transaction.
        ra[2] = 16'h0400; rw[2] = 1'b0; m_lat = 10;
        req_valid = 4'b0100;
        wait_grant("rst_wait_grant", 20);
        chk("rst_grant", grant, 4'b0100);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check_reset_outputs("rst_mid");
        saw = 1'b0;
        repeat (2) begin tick(); if (resp_done != '0) saw = 1'b1; end
        reset = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            ra[i] = 16'h0500 + 16'(i); rwd[i] = 32'h7000 + 32'(i); rw[i] = i[0];
        end
        req_valid = 4'b1111;

        // Contention: all four held; round-robin from requester 0.
        for (int k = 0; k < 5; k++) begin
            exp_w = k % NREQ;
            wait_grant($sformatf("rr%0d_wait_grant", k), 20);
            if (k == 0 && resp_done != '0) saw = 1'b1;
            chk($sformatf("rr%0d_grant", k), grant, NREQ'(1) << exp_w);
            wait_done($sformatf("rr%0d_wait_done", k), 40, n);
            chk($sformatf("rr%0d_done", k), resp_done, NREQ'(1) << exp_w);
            chk($sformatf("rr%0d_rdata", k), resp_rdata,
                (exp_w % 2 == 1) ? 32'h0 : rd_fn(16'h0500 + 16'(exp_w)));
            tick();
            chk($sformatf("rr%0d_single_pulse", k), resp_done, 0);
        end
        chk("rst_no_done", saw, 0);
        req_valid = '0;

        // Randomized phase against a transaction-level model.
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        rr_last = NREQ - 1; owner = 0; outstanding = 1'b0;
        idle_run = 0; prev_grant = '0; exp_rd = '0; exp_addr = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && !(outstanding && owner == i) && $urandom_range(0, 3) == 0) begin
                    ra[i] = 16'($urandom); rwd[i] = $urandom; rw[i] = 1'($urandom_range(0, 1));
                    req_valid[i] = 1'b1;
                end
            end
            if (outstanding && req_valid[owner] && $urandom_range(0, 15) == 0)
                req_valid[owner] = 1'b0;
            m_lat = $urandom_range(1, 6);
            tick();
            if (grant != '0 && prev_grant == '0) begin
                exp_w = -1;
                for (int k = 1; k <= NREQ; k++) begin
                    idx = (rr_last + k) % NREQ;
                    if (exp_w < 0 && req_valid[idx]) exp_w = idx;
                end
                if (exp_w < 0) begin
                    chk("rnd_grant_without_request", grant, 0);
                end else begin
                    exp_g = NREQ'(1) << exp_w;
                    chk("rnd_grant", grant, exp_g);
                    chk("rnd_mdout", m_dataOut, rwd[exp_w]);
                    chk("rnd_mwrite", m_requestIsWrite, rw[exp_w]);
                    owner = exp_w; rr_last = exp_w; outstanding = 1'b1;
                    exp_addr = ra[exp_w];
                    exp_rd = rw[exp_w] ? 32'h0 : rd_fn(ra[exp_w]);
                end
            end
            if (grant != '0 && outstanding)
                chk("rnd_maddr_stable", m_address, exp_addr);
            if (resp_done != '0) begin
                if (!outstanding) begin
                    chk("rnd_unexpected_done", resp_done, 0);
                end else begin
                    chk("rnd_done", resp_done, NREQ'(1) << owner);
                    chk("rnd_err", resp_err, 0);
                    chk("rnd_rdata", resp_rdata, exp_rd);
                    req_valid[owner] = 1'b0;
                    outstanding = 1'b0;
                end
            end
            if (req_valid != '0 && grant == '0) idle_run++;
            else idle_run = 0;
            if (idle_run > 4) begin
                chk("rnd_starvation", idle_run, 0);
                idle_run = 0;
            end
            prev_grant = grant;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
